// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes at launch and the sign is fixed up on the final iteration.
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mulstart,
  input  logic [1:0]      mulctl,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic [XLEN-1:0] mulres,
  output logic            exdone,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_ctl;
  logic [PW-1:0]   r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [PW-1:0]   r_acc;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_res;
  logic            r_done;

  logic            w_asgn;
  logic            w_bsgn;
  logic [XLEN-1:0] w_amag;
  logic [XLEN-1:0] w_bmag;
  logic [PW-1:0]   w_sum;
  logic [PW-1:0]   w_fin;

  assign w_asgn = (mulctl == 2'b01 || mulctl == 2'b10)
                  && srca[XLEN-1];
  assign w_bsgn = (mulctl == 2'b01) && srcb[XLEN-1];
  assign w_amag = w_asgn ? (~srca + 1'b1) : srca;
  assign w_bmag = w_bsgn ? (~srcb + 1'b1) : srcb;

  assign w_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_fin = r_neg ? (~w_sum + 1'b1) : w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ctl    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (mulstart) begin
            r_ctl    <= mulctl;
            r_mcand  <= {{XLEN{1'b0}}, w_amag};
            r_mplier <= w_bmag;
            r_neg    <= w_asgn ^ w_bsgn;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN - 1)) begin
            r_res   <= (r_ctl == 2'b00) ? w_fin[XLEN-1:0]
                                        : w_fin[PW-1:XLEN];
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mulres = r_res;
  assign exdone = r_done;
  assign busy   = (r_state != IDLE);

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU).
- Sits downstream of the datapath operand registers and is launched by the controller's `mulstart`/`mulctl`.
- Returns the selected 32-bit half of the product with a one-cycle `exdone` pulse, which the controller waits on before writeback.

Parameters:
- XLEN, 32, operand and result width; product is 2*XLEN internally.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mulstart  in  1  launch request; sampled only in IDLE.
- mulctl  in  2  operation select: 00 MUL (low half), 01 MULH (signed x signed, high), 10 MULHSU (signed x unsigned, high), 11 MULHU (unsigned x unsigned, high); equals func3[1:0].
- srca  in  XLEN  multiplicand (rs1 value).
- srcb  in  XLEN  multiplier (rs2 value).
- mulres  out  XLEN  result; registered, held until overwritten by the next completion.
- exdone  out  1  one-cycle completion pulse.
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state to IDLE.
  - mulres, exdone, busy, counter and internal accumulator/operand registers to 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - busy=0, exdone=0.
  - On an edge with mulstart=1 (edge E0):
    - latch mulctl.
    - Latch |srca| if srca is treated as signed (mulctl 01/10), else srca raw.
    - Latch |srcb| if srcb is treated as signed (mulctl 01 only), else srcb raw.
    - Latch negate flag = sign(a-as-signed) XOR sign(b-as-signed); a sign is 0 for any unsigned operand.
    - Clear the 2*XLEN accumulator; counter=0; go to BUSY.
  - srca/srcb/mulctl are not sampled again after E0.
- BUSY:
  - One iteration per edge: if the multiplier LSB is 1, add the shifted multiplicand into the accumulator; shift multiplicand left 1, multiplier right 1; counter++.
  - Magnitude of the most negative value (0x80000000) is taken as unsigned 2^31; no overflow.
  - On the edge where counter==XLEN-1 (edge E0+XLEN):
    - Form the final accumulator value.
    - If the negate flag is set, take its two's complement across 2*XLEN bits.
    - Write mulres: low XLEN bits for mulctl=00, high XLEN bits otherwise.
    - exdone<=1; go to DONE.
- DONE:
  - exdone=1 for exactly this one cycle.
  - Next edge: exdone<=0, go to IDLE.
  - mulstart is ignored in DONE; a launch is possible at the earliest on the edge after returning to IDLE.
- Latency: exdone is high during the cycle following edge E0+XLEN (XLEN+1 cycles from launch edge to pulse).
- mulstart asserted in BUSY or DONE is ignored; no queuing, no effect on the current operation.
- mulstart held high continuously: back-to-back operations every XLEN+2 cycles; operands are resampled at each IDLE launch.
- Zero operands still take the full XLEN iterations (no early termination).
- Reset mid-operation: immediate return to IDLE, no exdone pulse, mulres cleared to 0.
- busy equals (state != IDLE).

Test Plan:
- Reset with rst_n low, then release; mulres=0, exdone=0, busy=0. Launch MUL with srca=7, srcb=6 -> mulres=0x0000002A, exdone high only in the cycle after edge E0+32; busy high for 33 cycles.
- Signed operands -1 x -1: MUL srca=srcb=0xFFFFFFFF -> 0x00000001. MULH with the same operands -> 0x00000000. MULHU with the same operands -> 0xFFFFFFFE. MULHSU with the same operands (product -(2^32-1)) -> 0xFFFFFFFF.
- Most-negative operand: MULH srca=srcb=0x80000000 -> 0x40000000. MULHSU srca=0x80000000, srcb=0x00000002 -> 0xFFFFFFFF. MUL same -> 0x00000000.
- Busy/done handshake: pulse mulstart again at edges E0+5 and E0+33 with different operands -> first result unaffected, single exdone pulse. Hold mulstart high for 100 cycles -> exdone pulses exactly every 34 cycles.
- Reset mid-op: assert rst_n low asynchronously (between edges) at E0+10 -> busy and exdone drop immediately, mulres=0, no later pulse. After release, MULHU 0x12345678 x 0x9ABCDEF0 -> 0x0B00EA4E.
- Operands change after launch: change srca/srcb/mulctl on the cycle after E0 -> result reflects values latched at E0.
